// File: rtl/tx_line_state_gen.sv
// USB host line-state driver: takes over D+/D- from the packet transmitter to
// emit bus reset (SE0 then J) and, with TX_LINE_RESUME_EN, resume (K, SE0 x2, J).
module tx_line_state_gen #(
    parameter int RESET_CYCLES  = 480000,
    parameter int RESUME_CYCLES = 960000,
    parameter int FS_BIT_CYCLES = 4,
    parameter int LS_BIT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fullSpeedIn,
    input  logic       busResetReqIn,
    input  logic       resumeReqIn,
    input  logic       txBusyIn,
    output logic       lineCtrlActiveOut,
    output logic [1:0] txDataOut,
    output logic       busyOut,
    output logic       doneOut
);

    localparam int MAX_CYC = (RESET_CYCLES > RESUME_CYCLES) ? RESET_CYCLES : RESUME_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] RST_LOAD   = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] FS_J_LOAD  = CW'(FS_BIT_CYCLES - 1);
    localparam logic [CW-1:0] LS_J_LOAD  = CW'(LS_BIT_CYCLES - 1);

    localparam logic [1:0] SE0 = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_BUS = 3'd1,
        S_RST_SE0  = 3'd2,
`ifdef TX_LINE_RESUME_EN
        S_RES_K    = 3'd3,
        S_EOP_SE0  = 3'd4,
`endif
        S_EOP_J    = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_speed, w_speed_next;
    logic          r_op_reset, w_op_reset_next;
    logic          r_pend_reset, w_pend_reset_next;
    logic          w_pend_resume;
    logic          w_clr_reset, w_clr_resume;
    logic          w_cnt_zero;
    logic          w_reset_inprog;
    logic          w_resume_active;
    logic          w_abort;
    logic [CW-1:0] w_j_load;

    logic          w_active_next, w_busy_next, w_done_next;
    logic [1:0]    w_data_next;
    logic          r_active, r_busy, r_done;
    logic [1:0]    r_data;

    assign w_cnt_zero     = (r_cnt == '0);
    assign w_j_load       = r_speed ? FS_J_LOAD : LS_J_LOAD;
    assign w_reset_inprog = r_op_reset && ((r_state == S_RST_SE0) || (r_state == S_EOP_J));

`ifdef TX_LINE_RESUME_EN
    localparam logic [CW-1:0] RES_LOAD   = CW'(RESUME_CYCLES - 1);
    localparam logic [CW-1:0] FS_SE_LOAD = CW'(2 * FS_BIT_CYCLES - 1);
    localparam logic [CW-1:0] LS_SE_LOAD = CW'(2 * LS_BIT_CYCLES - 1);

    logic r_pend_resume, w_pend_resume_next;

    assign w_resume_active = !r_op_reset &&
                             ((r_state == S_RES_K) || (r_state == S_EOP_SE0) || (r_state == S_EOP_J));
    // A reset request pre-empts a running resume without passing through WAIT_BUS.
    assign w_abort         = w_resume_active && (busResetReqIn || r_pend_reset);
    assign w_pend_resume   = r_pend_resume;
    assign w_pend_resume_next = (r_pend_resume && !w_clr_resume) ||
                                (resumeReqIn && !r_pend_resume && !w_resume_active);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_pend_resume <= 1'b0;
        else      r_pend_resume <= w_pend_resume_next;
    end
`else
    logic w_unused;
    assign w_unused        = resumeReqIn ^ w_clr_resume;
    assign w_resume_active = 1'b0;
    assign w_abort         = 1'b0;
    assign w_pend_resume   = 1'b0;
`endif

    assign w_pend_reset_next = (r_pend_reset && !w_clr_reset) ||
                               (busResetReqIn && !r_pend_reset && !w_reset_inprog && !w_abort);

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = w_cnt_zero ? '0 : r_cnt - 1'b1;
        w_speed_next    = r_speed;
        w_op_reset_next = r_op_reset;
        w_clr_reset     = 1'b0;
        w_clr_resume    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend_reset || w_pend_resume) w_state_next = S_WAIT_BUS;
            end
            S_WAIT_BUS: begin
                if (!txBusyIn) begin
                    w_speed_next = fullSpeedIn;
                    if (r_pend_reset) begin
                        w_state_next    = S_RST_SE0;
                        w_cnt_next      = RST_LOAD;
                        w_op_reset_next = 1'b1;
                        w_clr_reset     = 1'b1;
`ifdef TX_LINE_RESUME_EN
                    end else if (r_pend_resume) begin
                        w_state_next    = S_RES_K;
                        w_cnt_next      = RES_LOAD;
                        w_op_reset_next = 1'b0;
                        w_clr_resume    = 1'b1;
`endif
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_RST_SE0: begin
                if (w_cnt_zero) begin
                    w_state_next = S_EOP_J;
                    w_cnt_next   = w_j_load;
                end
            end
`ifdef TX_LINE_RESUME_EN
            S_RES_K: begin
                if (w_abort) begin
                    w_state_next    = S_RST_SE0;
                    w_cnt_next      = RST_LOAD;
                    w_op_reset_next = 1'b1;
                    w_clr_reset     = 1'b1;
                end else if (w_cnt_zero) begin
                    w_state_next = S_EOP_SE0;
                    w_cnt_next   = r_speed ? FS_SE_LOAD : LS_SE_LOAD;
                end
            end
            S_EOP_SE0: begin
                if (w_abort) begin
                    w_state_next    = S_RST_SE0;
                    w_cnt_next      = RST_LOAD;
                    w_op_reset_next = 1'b1;
                    w_clr_reset     = 1'b1;
                end else if (w_cnt_zero) begin
                    w_state_next = S_EOP_J;
                    w_cnt_next   = w_j_load;
                end
            end
`endif
            S_EOP_J: begin
                if (w_abort) begin
                    w_state_next    = S_RST_SE0;
                    w_cnt_next      = RST_LOAD;
                    w_op_reset_next = 1'b1;
                    w_clr_reset     = 1'b1;
                end else if (w_cnt_zero) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = (r_pend_reset || w_pend_resume) ? S_WAIT_BUS : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so the wire level lines up with the state.
    always_comb begin
        w_active_next = 1'b0;
        w_data_next   = fullSpeedIn ? 2'b10 : 2'b01;
        case (w_state_next)
            S_RST_SE0: begin
                w_active_next = 1'b1;
                w_data_next   = SE0;
            end
`ifdef TX_LINE_RESUME_EN
            S_RES_K: begin
                w_active_next = 1'b1;
                w_data_next   = w_speed_next ? 2'b01 : 2'b10;
            end
            S_EOP_SE0: begin
                w_active_next = 1'b1;
                w_data_next   = SE0;
            end
`endif
            S_EOP_J: begin
                w_active_next = 1'b1;
                w_data_next   = w_speed_next ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end

    assign w_busy_next = (w_state_next != S_IDLE);
    assign w_done_next = (w_state_next == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_speed      <= 1'b0;
            r_op_reset   <= 1'b0;
            r_pend_reset <= 1'b0;
            r_active     <= 1'b0;
            r_data       <= 2'b00;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_speed      <= w_speed_next;
            r_op_reset   <= w_op_reset_next;
            r_pend_reset <= w_pend_reset_next;
            r_active     <= w_active_next;
            r_data       <= w_data_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
        end
    end

    assign lineCtrlActiveOut = r_active;
    assign txDataOut         = r_data;
    assign busyOut           = r_busy;
    assign doneOut           = r_done;

endmodule

// File: tb/tb_tx_line_state_gen.sv
// Scoreboard bench for tx_line_state_gen: stimulus pushes expected line runs and
// done pulses; a negedge monitor run-length-encodes the wires and compares.
module tb_tx_line_state_gen;

    localparam int RC  = 20;
    localparam int RSC = 40;
    localparam int FSB = 4;
    localparam int LSB = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fs  = 1'b1;
    logic       brq = 1'b0;
    logic       rrq = 1'b0;
    logic       txb = 1'b0;
    logic       active;
    logic [1:0] data;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    tx_line_state_gen #(
        .RESET_CYCLES (RC),
        .RESUME_CYCLES(RSC),
        .FS_BIT_CYCLES(FSB),
        .LS_BIT_CYCLES(LSB)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fullSpeedIn      (fs),
        .busResetReqIn    (brq),
        .resumeReqIn      (rrq),
        .txBusyIn         (txb),
        .lineCtrlActiveOut(active),
        .txDataOut        (data),
        .busyOut          (busy),
        .doneOut          (done)
    );

    typedef struct {
        bit         is_done;
        logic [1:0] lvl;
        int         len;
    } seg_t;

    seg_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] jl(input bit f); return f ? 2'b10 : 2'b01; endfunction
    function automatic logic [1:0] kl(input bit f); return f ? 2'b01 : 2'b10; endfunction
    function automatic int bitc(input bit f); return f ? FSB : LSB; endfunction

    task automatic push_seg(input logic [1:0] l, input int n);
        seg_t s;
        s.is_done = 1'b0; s.lvl = l; s.len = n;
        exp_q.push_back(s);
    endtask

    task automatic push_done();
        seg_t s;
        s.is_done = 1'b1; s.lvl = 2'b00; s.len = 0;
        exp_q.push_back(s);
    endtask

    task automatic push_reset(input bit f);
        push_seg(2'b00, RC);
        push_seg(jl(f), bitc(f));
        push_done();
    endtask

    task automatic push_resume(input bit f);
        push_seg(kl(f), RSC);
        push_seg(2'b00, 2 * bitc(f));
        push_seg(jl(f), bitc(f));
        push_done();
    endtask

    // Monitor: one line per completed run or done pulse.
    task automatic close_run(input logic [1:0] l, input int n);
        seg_t s;
        if (exp_q.size() == 0) begin
            chk("unexpected_run", n, 0);
        end else begin
            s = exp_q.pop_front();
            $display("run level=%b len=%0d (expect level=%b len=%0d)", l, n, s.lvl, s.len);
            chk("run_kind", int'(s.is_done), 0);
            chk("run_level", int'(l), int'(s.lvl));
            chk("run_len", n, s.len);
        end
    endtask

    initial begin : monitor
        bit         in_run;
        logic [1:0] cur_lvl;
        int         cur_len;
        seg_t       s;
        in_run  = 1'b0;
        cur_lvl = 2'b00;
        cur_len = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_run = 1'b0;
            end else begin
                if (active && in_run && data == cur_lvl) begin
                    cur_len++;
                end else begin
                    if (in_run) close_run(cur_lvl, cur_len);
                    in_run  = active;
                    cur_lvl = data;
                    cur_len = 1;
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        s = exp_q.pop_front();
                        $display("done pulse active=%b", active);
                        chk("done_kind", int'(s.is_done), 1);
                        chk("done_active", int'(active), 0);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input bit r, input bit s);
        brq = r;
        rrq = s;
        tick(1);
        brq = 1'b0;
        rrq = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit rand_fs);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            if (rand_fs) fs = 1'($urandom);
            tick(1);
            n++;
        end
        chk("idle_within_budget", int'(n < budget), 1);
    endtask

    task automatic wait_active(input int budget);
        int n = 0;
        while (active !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        chk("active_within_budget", int'(n < budget), 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        #1;
        chk("rst_active", int'(active), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        #11 rst = 1'b1;
        tick(2);

        // Full-speed bus reset with request-to-drive latency.
        fs = 1'b1;
        push_reset(1'b1);
        pulse_req(1'b1, 1'b0);
        tick(1);
        chk("lat_busy", int'(busy), 1);
        chk("lat_inactive", int'(active), 0);
        tick(1);
        chk("lat_active", int'(active), 1);
        chk("lat_se0", int'(data), 0);
        wait_idle(200, 1'b0);
        $display("bus reset fs complete");

`ifdef TX_LINE_RESUME_EN
        fs = 1'b0;
        push_resume(1'b0);
        pulse_req(1'b0, 1'b1);
        tick(1);
        wait_idle(400, 1'b0);
        $display("resume ls complete");
`else
        pulse_req(1'b0, 1'b1);
        tick(3);
        chk("resume_ignored_busy", int'(busy), 0);
        chk("resume_ignored_active", int'(active), 0);
        $display("resume request ignored");
`endif

        // Held off by the packet transmitter.
        fs  = 1'b1;
        txb = 1'b1;
        push_reset(1'b1);
        pulse_req(1'b1, 1'b0);
        tick(1);
        for (int i = 0; i < 14; i++) begin
            chk("hold_busy", int'(busy), 1);
            chk("hold_inactive", int'(active), 0);
            tick(1);
        end
        txb = 1'b0;
        chk("hold_last_inactive", int'(active), 0);
        tick(1);
        chk("hold_release_active", int'(active), 1);
        wait_idle(200, 1'b0);
        $display("txBusy hold-off complete");

        // Simultaneous requests.
        push_reset(1'b1);
`ifdef TX_LINE_RESUME_EN
        push_resume(1'b1);
`endif
        pulse_req(1'b1, 1'b1);
        tick(1);
        wait_idle(600, 1'b0);
        $display("simultaneous requests complete");

`ifdef TX_LINE_RESUME_EN
        // Reset request during cycle 10 of K aborts the resume.
        fs = 1'b1;
        pulse_req(1'b0, 1'b1);
        wait_active(20);
        tick(9);
        push_seg(kl(1'b1), 10);
        push_reset(1'b1);
        brq = 1'b1;
        tick(1);
        brq = 1'b0;
        chk("abort_active", int'(active), 1);
        chk("abort_se0", int'(data), 0);
        wait_idle(300, 1'b0);
        $display("resume abort complete");
`endif

        // Asynchronous reset in the middle of SE0.
        push_reset(1'b1);
        pulse_req(1'b1, 1'b0);
        wait_active(20);
        tick(5);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_active", int'(active), 0);
        chk("mid_rst_data", int'(data), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        exp_q.delete();
        tick(2);
        #2 rst = 1'b1;
        tick(5);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_active", int'(active), 0);
        $display("mid-operation reset complete");

        // Random operations, speed and hold-off; speed wiggles after start.
        for (int k = 0; k < 12; k++) begin
            bit f;
            bit res;
            int dly;
            f   = 1'($urandom);
`ifdef TX_LINE_RESUME_EN
            res = 1'($urandom);
`else
            res = 1'b0;
`endif
            dly = int'($urandom_range(0, 6));
            fs  = f;
            txb = (dly > 0);
            if (res) push_resume(f);
            else     push_reset(f);
            pulse_req(!res, res);
            if (dly > 0) tick(dly);
            txb = 1'b0;
            wait_active(30);
            wait_idle(400, 1'b1);
            $display("random op %0d resume=%0d fs=%0d hold=%0d complete", k, res, f, dly);
        end

        tick(5);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
